// File: rtl/mac_row_seq_pkg.sv
// Shared definitions for the CIOS row engine: row sequencer state encoding,
// default word geometry and the MonPro operand parameters.
package mac_row_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } row_state_e;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_NUM_WORDS  = 16;

  localparam int MONPRO_WORD_W        = DEF_DATA_WIDTH;
  localparam int MONPRO_OPERAND_WORDS = DEF_NUM_WORDS;
  localparam int MONPRO_ROW_WORDS     = MONPRO_OPERAND_WORDS + 1;

endpackage

// File: rtl/mac_row_seq_mul_add.sv
// Combinational word multiply-add: {c,s} = x*y + z + last_c.
// The 2W-bit result cannot overflow since (2^W-1)^2 + 2(2^W-1) = 2^2W - 1.
module mul_add
  import mac_row_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] z,
  input  logic [DATA_WIDTH-1:0] last_c,
  output logic [DATA_WIDTH-1:0] s,
  output logic [DATA_WIDTH-1:0] c
);

  logic [2*DATA_WIDTH-1:0] w_full;

  assign w_full = (2*DATA_WIDTH)'(x) * (2*DATA_WIDTH)'(y)
                + (2*DATA_WIDTH)'(z) + (2*DATA_WIDTH)'(last_c);
  assign s = w_full[DATA_WIDTH-1:0];
  assign c = w_full[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/mac_row_seq.sv
// Word-serial row sequencer computing R = A*b + T, streaming N+1 words LSW first.
// Optional MAC_ROW_CARRY_IN_EN adds c_init to seed the carry for row chaining.
module mac_row_seq
  import mac_row_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MAC_ROW_CARRY_IN_EN
  input  logic [DATA_WIDTH-1:0] c_init,
`endif
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_t,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_word,
  output logic                  out_last
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  row_state_e            r_state;
  row_state_e            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_carry;
  logic [DATA_WIDTH-1:0] r_out_word;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_cout;
  logic [DATA_WIDTH-1:0] w_seed;
  logic                  w_xfer;
  logic                  w_load_carry;
  logic                  w_ret;

`ifdef MAC_ROW_CARRY_IN_EN
  assign w_seed = c_init;
`else
  assign w_seed = '0;
`endif

  mul_add #(.DATA_WIDTH(DATA_WIDTH)) u_mul_add (
    .x      (in_a),
    .y      (r_b),
    .z      (in_t),
    .last_c (r_carry),
    .s      (w_sum),
    .c      (w_cout)
  );

  // The output register may take a new word whenever it is empty or draining.
  assign in_ready     = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_xfer       = in_valid && in_ready;
  assign w_load_carry = (r_state == ST_FLUSH) && !r_out_last && (!r_out_valid || out_ready);
  assign w_ret        = (r_state == ST_FLUSH) && r_out_last && out_ready;

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_last  = r_out_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_xfer && (r_cnt == LAST_IDX)) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_ret) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b         <= '0;
      r_carry     <= '0;
      r_cnt       <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_ret;
      if ((r_state == ST_IDLE) && start) begin
        r_b     <= b;
        r_carry <= w_seed;
        r_cnt   <= '0;
      end
      if (w_xfer) begin
        r_out_word  <= w_sum;
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b0;
        r_carry     <= w_cout;
        r_cnt       <= r_cnt + CNT_W'(1);
      end else if (w_load_carry) begin
        r_out_word  <= r_carry;
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_row_seq.sv
// Self-checking bench for mac_row_seq (8-bit words, 4-word and 1-word rows).
// Build with MAC_ROW_CARRY_IN_EN defined to also exercise the c_init port.
module tb_mac_row_seq;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int RW = (N + 1) * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, in_valid, out_ready;
  logic [W-1:0] b, in_a, in_t;
  logic         busy, done, in_ready, out_valid, out_last;
  logic [W-1:0] out_word;

  logic         start1, in_valid1, out_ready1;
  logic [W-1:0] b1, in_a1, in_t1;
  logic         busy1, done1, in_ready1, out_valid1, out_last1;
  logic [W-1:0] out_word1;
`ifdef MAC_ROW_CARRY_IN_EN
  logic [W-1:0] c_init, c_init1;
`endif

  mac_row_seq #(.DATA_WIDTH(W), .NUM_WORDS(N)) dut (
`ifdef MAC_ROW_CARRY_IN_EN
    .c_init(c_init),
`endif
    .clk(clk), .rst(rst), .start(start), .b(b), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_t(in_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_last(out_last)
  );

  mac_row_seq #(.DATA_WIDTH(W), .NUM_WORDS(1)) dut1 (
`ifdef MAC_ROW_CARRY_IN_EN
    .c_init(c_init1),
`endif
    .clk(clk), .rst(rst), .start(start1), .b(b1), .busy(busy1), .done(done1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_t(in_t1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_word(out_word1), .out_last(out_last1)
  );

  typedef struct {
    logic [W-1:0]   b;
    logic [N*W-1:0] a;
    logic [N*W-1:0] t;
    logic [W-1:0]   ci;
    int             rmode;
    int             gap;
    bit             poke;
    logic [RW-1:0]  exp;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: the whole row is one big integer A*b + T + carry-in.
  function automatic logic [RW-1:0] row_model(input logic [W-1:0] bb, input logic [N*W-1:0] a,
                                              input logic [N*W-1:0] t, input logic [W-1:0] ci);
    return RW'(a) * RW'(bb) + RW'(t) + RW'(ci);
  endfunction

  task automatic run_row(input vec_t v, input string tag);
    logic [RW-1:0] got;
    int            nw, idx, gcnt, last_cyc;
    bit            seen_done, prev_stall;
    logic [W-1:0]  prev_w;
    logic          prev_l;
    @(negedge clk);
    start = 1'b1; b = v.b; in_valid = 1'b0; out_ready = 1'b0;
`ifdef MAC_ROW_CARRY_IN_EN
    c_init = v.ci;
`endif
    @(negedge clk);
    start = 1'b0; b = W'($urandom);
    #1 check({tag, "_busy"}, busy, 1);
    got = '0; nw = 0; idx = 0; gcnt = 0; last_cyc = -10;
    seen_done = 0; prev_stall = 0; prev_w = '0; prev_l = 0;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done) begin
        seen_done = 1;
        check({tag, "_done_lat"}, cyc, last_cyc + 1);
        check({tag, "_busy_end"}, busy, 0);
      end else begin
        case (v.rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc % 3 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        start = v.poke && (cyc == 2);
        if (start) b = W'($urandom);
        if (gcnt > 0) begin
          in_valid = 1'b0; gcnt--;
        end else if (idx < N) begin
          in_valid = 1'b1; in_a = v.a[idx*W +: W]; in_t = v.t[idx*W +: W];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (prev_stall) begin
          check({tag, "_stall_word"}, out_word, prev_w);
          check({tag, "_stall_last"}, out_last, prev_l);
        end
        if (out_valid && !out_ready) check({tag, "_in_ready_stall"}, in_ready, 0);
        if (out_valid && out_ready && nw <= N) begin
          got[nw*W +: W] = out_word;
          check({tag, "_last_flag"}, out_last, (nw == N));
          if (out_last) last_cyc = cyc;
          nw++;
        end
        if (in_valid && in_ready) begin
          idx++; gcnt = v.gap;
        end
        prev_stall = out_valid && !out_ready;
        prev_w = out_word; prev_l = out_last;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_row"}, got, v.exp);
    check({tag, "_nwords"}, nw, N + 1);
    if (v.rmode == 0 && v.gap == 0) check({tag, "_bubble_free"}, last_cyc, N + 1);
    @(negedge clk);
    #1 check({tag, "_done_pulse"}, done, 0);
  endtask

  vec_t tbl[6];
  int   nvec;
  vec_t rv;

  initial begin
    rst = 1'b1; start = 0; b = 0; in_valid = 0; in_a = 0; in_t = 0; out_ready = 0;
    start1 = 0; b1 = 0; in_valid1 = 0; in_a1 = 0; in_t1 = 0; out_ready1 = 0;
`ifdef MAC_ROW_CARRY_IN_EN
    c_init = 0; c_init1 = 0;
`endif
    tbl[0] = '{b: 8'hFF, a: 32'hFFFFFFFF, t: 32'hFFFFFFFF, ci: 0, rmode: 0, gap: 0, poke: 0, exp: 40'hFFFFFFFF00};
    tbl[1] = '{b: 8'h02, a: 32'h00008080, t: 32'h0,        ci: 0, rmode: 0, gap: 0, poke: 0, exp: 40'h0000010100};
    tbl[2] = '{b: 8'hFF, a: 32'hFFFFFFFF, t: 32'hFFFFFFFF, ci: 0, rmode: 1, gap: 0, poke: 0, exp: 40'hFFFFFFFF00};
    tbl[3] = '{b: 8'hFF, a: 32'hFFFFFFFF, t: 32'hFFFFFFFF, ci: 0, rmode: 0, gap: 3, poke: 0, exp: 40'hFFFFFFFF00};
    tbl[4] = '{b: 8'h02, a: 32'h00008080, t: 32'h0,        ci: 0, rmode: 0, gap: 0, poke: 1, exp: 40'h0000010100};
    nvec = 5;
`ifdef MAC_ROW_CARRY_IN_EN
    tbl[5] = '{b: 8'h00, a: 32'h0, t: 32'h0, ci: 8'h01, rmode: 0, gap: 0, poke: 0, exp: 40'h0000000001};
    nvec = 6;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < nvec; i++) run_row(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      rv.b = W'($urandom); rv.a = $urandom; rv.t = $urandom;
`ifdef MAC_ROW_CARRY_IN_EN
      rv.ci = W'($urandom);
`else
      rv.ci = '0;
`endif
      rv.rmode = 2; rv.gap = $urandom_range(0, 2); rv.poke = 0;
      rv.exp = row_model(rv.b, rv.a, rv.t, rv.ci);
      run_row(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a row: partial row discarded, no done.
    @(negedge clk); start = 1'b1; b = 8'hFF; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_a = 8'hFF; in_t = 8'hFF;
    @(negedge clk); in_a = 8'h12;
    @(negedge clk); in_valid = 1'b0;
    #1 check("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    repeat (3) begin
      @(negedge clk);
      #1 check("mid_rst_no_done", done, 0);
    end
    out_ready = 1'b0;
    rv = '{b: 8'h00, a: 32'h0, t: 32'h0, ci: 0, rmode: 0, gap: 0, poke: 0, exp: 40'h0};
    run_row(rv, "after_rst");

    // Single-word row: FF*FF = FE01.
    @(negedge clk); start1 = 1'b1; b1 = 8'hFF;
    @(negedge clk); start1 = 1'b0; in_valid1 = 1'b1; in_a1 = 8'hFF; in_t1 = 8'h00; out_ready1 = 1'b1;
    @(negedge clk); in_valid1 = 1'b0;
    #1;
    check("n1_valid0", out_valid1, 1);
    check("n1_word0", out_word1, 8'h01);
    check("n1_last0", out_last1, 0);
    @(negedge clk);
    #1;
    check("n1_word1", out_word1, 8'hFE);
    check("n1_last1", out_last1, 1);
    @(negedge clk);
    #1;
    check("n1_done", done1, 1);
    check("n1_busy", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
